// File: rtl/pcie_wrap0_st_pkg.sv
// Purpose: shared FSM encoding, beat layout helpers and counter arithmetic for the ST channel filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcie_wrap0_st_pkg;

    // Per-packet filter state; only accepted beats move it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } st_state_t;

    // Beat layout inside the skid stage, MSB first: {sop, eop, chan, data}.
    function automatic int beat_w(input int data_w, input int ch_w);
        return data_w + ch_w + 2;
    endfunction

    function automatic int chan_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int eop_bit(input int data_w, input int ch_w);
        return data_w + ch_w;
    endfunction

    function automatic int sop_bit(input int data_w, input int ch_w);
        return data_w + ch_w + 1;
    endfunction

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
        return (cnt >= max_val) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/pcie_wrap0_st_skid_buffer.sv
// Purpose: 2-entry registered ready/valid stage (output reg + skid reg), order preserving.
// Latency: 1 cycle from accepted input to out_vld when the output is not stalled.
// Backpressure: in_rdy is registered and drops only when both entries will be full; 1 beat/cycle sustained.
// Ports: clk/reset_n; in_vld/in_rdy/in_dat sink side; out_vld/out_rdy/out_dat source side.
module pcie_wrap0_st_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         sk_vld;
    logic [W-1:0] sk_dat;
    logic         push;
    logic         pop;
    logic         sk_vld_nxt;

    assign push = in_vld & in_rdy;
    assign pop  = out_vld & out_rdy;

    // The skid entry is occupied next cycle if it holds data that cannot move up,
    // or if a new beat arrives while the output register is stalled.
    assign sk_vld_nxt = (sk_vld & ~pop) | (out_vld & ~pop & push);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            sk_vld  <= 1'b0;
            sk_dat  <= '0;
            in_rdy  <= 1'b0;
        end else begin
            in_rdy <= ~sk_vld_nxt;
            sk_vld <= sk_vld_nxt;
            if (!out_vld || pop) begin
                // Skid entry is older than anything arriving now, so it moves up first.
                if (sk_vld) begin
                    out_vld <= 1'b1;
                    out_dat <= sk_dat;
                end else begin
                    out_vld <= push;
                    if (push) begin
                        out_dat <= in_dat;
                    end
                end
            end
            if (out_vld && !pop && push) begin
                sk_dat <= in_dat;
            end
        end
    end

endmodule

// File: rtl/pcie_wrap0_st_channel_filter.sv
// Purpose: Avalon-ST channel narrowing adapter that forwards or drops whole packets by channel.
// Latency: 1 cycle for forwarded beats (registered skid stage); dropped beats are consumed silently.
// Backpressure: in_ready is registered from the skid stage; drops only when both skid entries fill.
// Ports: clk/reset_n; in_* Avalon-ST sink; out_* Avalon-ST source with OUT_CH_W channel;
//        drop_count/err_count saturating packet-drop and framing-error counters.
module pcie_wrap0_st_channel_filter
    import pcie_wrap0_st_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int IN_CH_W     = 8,
    parameter int OUT_CH_W    = 1,
    parameter int MAX_CHANNEL = 0,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                in_ready,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [IN_CH_W-1:0]  in_channel,
    input  logic                in_startofpacket,
    input  logic                in_endofpacket,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [OUT_CH_W-1:0] out_channel,
    output logic                out_startofpacket,
    output logic                out_endofpacket,
    output logic [CNT_W-1:0]    drop_count,
    output logic [CNT_W-1:0]    err_count
);

    localparam int                 BEAT_W  = beat_w(DATA_W, OUT_CH_W);
    localparam int                 CH_LSB  = chan_lsb(DATA_W);
    localparam int                 EOP_IDX = eop_bit(DATA_W, OUT_CH_W);
    localparam int                 SOP_IDX = sop_bit(DATA_W, OUT_CH_W);
    localparam logic [IN_CH_W-1:0] MAX_CH  = IN_CH_W'(MAX_CHANNEL);
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    st_state_t           state;
    st_state_t           state_nxt;
    logic [OUT_CH_W-1:0] chan_r;
    logic [OUT_CH_W-1:0] beat_chan;
    logic                chan_ok;
    logic                accept;
    logic                fwd;
    logic                drop_evt;
    logic                err_evt;
    logic [BEAT_W-1:0]   beat_in;
    logic [BEAT_W-1:0]   beat_out;

    assign chan_ok = (in_channel <= MAX_CH);
    assign accept  = in_valid & in_ready;

    // Filter decision for the beat currently on the input. A SOP always starts a
    // fresh packet, even inside an unterminated one; that case is also a framing error.
    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        drop_evt  = 1'b0;
        err_evt   = 1'b0;
        beat_chan = chan_r;
        if (in_startofpacket) begin
            beat_chan = in_channel[OUT_CH_W-1:0];
            fwd       = chan_ok;
            drop_evt  = ~chan_ok;
            err_evt   = (state != ST_IDLE);
            if (in_endofpacket) begin
                state_nxt = ST_IDLE;
            end else begin
                state_nxt = chan_ok ? ST_FWD : ST_DROP;
            end
        end else begin
            case (state)
                ST_IDLE: err_evt = 1'b1;    // orphan beat: discarded
                ST_FWD: begin
                    fwd = 1'b1;
                    if (in_endofpacket) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (in_endofpacket) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            chan_r     <= '0;
            drop_count <= '0;
            err_count  <= '0;
        end else if (accept) begin
            state <= state_nxt;
            if (in_startofpacket) begin
                chan_r <= in_channel[OUT_CH_W-1:0];
            end
            if (drop_evt) begin
                drop_count <= CNT_W'(sat_inc(32'(drop_count), 32'(CNT_MAX)));
            end
            if (err_evt) begin
                err_count <= CNT_W'(sat_inc(32'(err_count), 32'(CNT_MAX)));
            end
        end
    end

    assign beat_in = {in_startofpacket, in_endofpacket, beat_chan, in_data};

    // Only forwarded beats are offered to the skid stage; dropped beats are still
    // acknowledged through in_ready and simply vanish.
    pcie_wrap0_st_skid_buffer #(
        .W(BEAT_W)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .in_vld  (in_valid & fwd),
        .in_rdy  (in_ready),
        .in_dat  (beat_in),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (beat_out)
    );

    assign out_startofpacket = beat_out[SOP_IDX];
    assign out_endofpacket   = beat_out[EOP_IDX];
    assign out_channel       = beat_out[CH_LSB +: OUT_CH_W];
    assign out_data          = beat_out[DATA_W-1:0];

endmodule

// File: tb/tb_pcie_wrap0_st_channel_filter.sv
// Purpose: directed scoreboard bench for the ST channel filter (forward, drop, errors, backpressure, reset).
// Latency: checks 1-cycle forward latency on unstalled traffic.
// Backpressure: exercises a 5-cycle output stall and checks stability and in_ready behaviour.
module tb_pcie_wrap0_st_channel_filter;

    localparam int DATA_W      = 8;
    localparam int IN_CH_W     = 8;
    localparam int OUT_CH_W    = 1;
    localparam int MAX_CHANNEL = 0;
    localparam int CNT_W       = 2;

    typedef struct packed {
        logic                sop;
        logic                eop;
        logic [OUT_CH_W-1:0] ch;
        logic [DATA_W-1:0]   data;
    } beat_t;

    typedef struct {
        beat_t b;
        int    acc;
        bit    lat;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_ready;
    logic                in_valid = 1'b0;
    logic [DATA_W-1:0]   in_data = '0;
    logic [IN_CH_W-1:0]  in_channel = '0;
    logic                in_startofpacket = 1'b0;
    logic                in_endofpacket = 1'b0;
    logic                out_ready = 1'b1;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [OUT_CH_W-1:0] out_channel;
    logic                out_startofpacket;
    logic                out_endofpacket;
    logic [CNT_W-1:0]    drop_count;
    logic [CNT_W-1:0]    err_count;

    pcie_wrap0_st_channel_filter #(
        .DATA_W      (DATA_W),
        .IN_CH_W     (IN_CH_W),
        .OUT_CH_W    (OUT_CH_W),
        .MAX_CHANNEL (MAX_CHANNEL),
        .CNT_W       (CNT_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .in_ready          (in_ready),
        .in_valid          (in_valid),
        .in_data           (in_data),
        .in_channel        (in_channel),
        .in_startofpacket  (in_startofpacket),
        .in_endofpacket    (in_endofpacket),
        .out_ready         (out_ready),
        .out_valid         (out_valid),
        .out_data          (out_data),
        .out_channel       (out_channel),
        .out_startofpacket (out_startofpacket),
        .out_endofpacket   (out_endofpacket),
        .drop_count        (drop_count),
        .err_count         (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    bit   lat_mode = 1'b0;
    logic [IN_CH_W-1:0] pkt_ch = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks stall stability.
    beat_t prev_beat;
    bit    prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        exp_t  e;
        cur = {out_startofpacket, out_endofpacket, out_channel, out_data};
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'(cur), 32'(prev_beat));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", cur);
                end else begin
                    e = q.pop_front();
                    chk("beat", 32'(cur), 32'(e.b));
                    if (e.lat) chk("latency", 32'(cyc), 32'(e.acc + 1));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur;
        end
    end

    // Drive one beat and hold it until accepted; fwd says whether it must appear on the output.
    task automatic send(input logic sop, input logic eop, input logic [IN_CH_W-1:0] ch,
                        input logic [DATA_W-1:0] data, input bit fwd);
        int   t;
        exp_t e;
        in_valid         = 1'b1;
        in_startofpacket = sop;
        in_endofpacket   = eop;
        in_channel       = ch;
        in_data          = data;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        if (sop) pkt_ch = ch;
        if (fwd) begin
            e.b   = {sop, eop, pkt_ch[OUT_CH_W-1:0], data};
            e.acc = cyc;
            e.lat = lat_mode;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_out_data", 32'(out_data), 32'd0);

        // 1: 3-beat ch0 packet, mid-packet channel ignored, 1-cycle latency.
        lat_mode = 1'b1;
        send(1'b1, 1'b0, 8'd0, 8'h11, 1'b1);
        send(1'b0, 1'b0, 8'd7, 8'h12, 1'b1);
        send(1'b0, 1'b1, 8'd7, 8'h13, 1'b1);
        lat_mode = 1'b0;
        idle(3);
        chk("t1_drop", 32'(drop_count), 32'd0);

        // 2: ch2 packet dropped, ch0 packet forwarded, no stalls.
        t0 = cyc;
        send(1'b1, 1'b0, 8'd2, 8'h21, 1'b0);
        send(1'b0, 1'b0, 8'd0, 8'h22, 1'b0);
        send(1'b0, 1'b0, 8'd0, 8'h23, 1'b0);
        send(1'b0, 1'b1, 8'd0, 8'h24, 1'b0);
        send(1'b1, 1'b0, 8'd0, 8'h25, 1'b1);
        send(1'b0, 1'b1, 8'd0, 8'h26, 1'b1);
        chk("t2_cycles", 32'(cyc - t0), 32'd6);
        idle(3);
        chk("t2_drop", 32'(drop_count), 32'd1);

        // 3: eight single-beat packets at full rate.
        lat_mode = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(1'b1, 1'b1, 8'd0, 8'(8'h30 + i), 1'b1);
        chk("t3_cycles", 32'(cyc - t0), 32'd8);
        lat_mode = 1'b0;
        idle(3);
        chk("t3_err", 32'(err_count), 32'd0);

        // 4: 5-cycle output stall mid-packet.
        fork
            begin
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("t4_in_ready_low", 32'(in_ready), 32'd0);
                chk("t4_out_valid", 32'(out_valid), 32'd1);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join_none
        send(1'b1, 1'b0, 8'd0, 8'h40, 1'b1);
        for (int i = 1; i < 5; i++) send(1'b0, 1'b0, 8'd0, 8'(8'h40 + i), 1'b1);
        send(1'b0, 1'b1, 8'd0, 8'h45, 1'b1);
        idle(5);
        chk("t4_drop", 32'(drop_count), 32'd1);
        chk("t4_err", 32'(err_count), 32'd0);

        // 5: orphan beat and SOP inside packets.
        do_reset();
        send(1'b0, 1'b0, 8'd0, 8'h50, 1'b0);
        chk("t5_orphan_err", 32'(err_count), 32'd1);
        send(1'b1, 1'b0, 8'd0, 8'h51, 1'b1);
        send(1'b0, 1'b0, 8'd3, 8'h52, 1'b1);
        send(1'b1, 1'b0, 8'd0, 8'h53, 1'b1);
        chk("t5_sop_in_pkt_err", 32'(err_count), 32'd2);
        send(1'b0, 1'b1, 8'd0, 8'h54, 1'b1);
        send(1'b1, 1'b0, 8'd0, 8'h55, 1'b1);
        send(1'b1, 1'b0, 8'd3, 8'h56, 1'b0);
        send(1'b0, 1'b1, 8'd0, 8'h57, 1'b0);
        idle(3);
        chk("t5_err", 32'(err_count), 32'd3);
        chk("t5_drop", 32'(drop_count), 32'd1);

        // 6: drop counter saturation, then reset mid-packet.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            send(1'b1, 1'b0, 8'd9, 8'(8'h60 + p), 1'b0);
            send(1'b0, 1'b1, 8'd9, 8'h6f, 1'b0);
        end
        chk("t6_drop_sat", 32'(drop_count), 32'd3);
        chk("t6_err", 32'(err_count), 32'd0);
        out_ready = 1'b0;
        send(1'b1, 1'b0, 8'd0, 8'h70, 1'b1);
        send(1'b0, 1'b0, 8'd0, 8'h71, 1'b1);
        reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_drop", 32'(drop_count), 32'd0);
        chk("t6_rst_err", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(1'b0, 1'b0, 8'd0, 8'h72, 1'b0);
        send(1'b0, 1'b1, 8'd0, 8'h73, 1'b0);
        idle(5);
        chk("t6_orphan_err", 32'(err_count), 32'd2);
        chk("t6_drop_after", 32'(drop_count), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
